spi_mem_responder: RTL
======================

Name: spi_mem_responder

Overview:
- Synthesizable SPI mode-0 slave memory that answers the processor's SPI initiator (sclk/cs/mosi out, miso in). It is the responder end of the link the processor uses to fetch instructions and data.
- Replaces the behavioural device model on the FPGA demo board.
- Holds a DEPTH x 8 byte array. The array is preloaded through a parallel load port and then served over SPI with read/write commands and address auto-increment.

Parameters:
- DEPTH, 16, number of bytes in the array (power of two).
- ADDR_W, $clog2(DEPTH), internal address width; only the low ADDR_W bits of the SPI address byte are used.

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency
- rst  input  1  asynchronous, active-high reset
- sclk  input  1  SPI clock from the initiator, asynchronous to clk
- cs  input  1  active-low chip select
- mosi  input  1  serial data from the initiator
- miso  output  1  serial data to the initiator
- ld_we  input  1  parallel load strobe
- ld_addr  input  ADDR_W  load address
- ld_data  input  8  load data
- busy  output  1  high while cs is low (synchronised)
- done  output  1  one-cycle pulse on cs deassertion
- txn_count  output  8  completed-transaction counter (see Optional Feature)

Behaviour:
- Reset values: miso=0, busy=0, done=0, txn_count=0, state=IDLE, shift regs=0. Memory contents are not reset.
- sclk, cs and mosi pass through a 2-flop synchroniser, then an edge detector that produces sclk_rise, sclk_fall, cs_fall and cs_rise pulses.
- Protocol: mode 0, MSB first.
  - mosi is sampled on sclk_rise.
  - miso is updated on sclk_fall.
  - miso changes at most 3 clk after the raw falling sclk edge.
- Transaction layout: command byte, then address byte, then data bytes.
  - 0x03 = READ, 0x02 = WRITE.
- FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE -> CMD on cs_fall; bit counter cleared.
  - CMD -> ADDR after 8 rising edges if the command is 0x03 or 0x02; any other opcode -> IGNORE.
  - ADDR -> READ or WRITE after 8 rising edges; addr <= byte[ADDR_W-1:0].
    - For READ, mem[addr] is loaded into the tx shift register in the same cycle as that 8th rising edge.
    - The following sclk_fall presents bit 7 on miso.
  - READ: each sclk_fall shifts the next bit out. After bit 0 is shifted out, addr increments and mem[addr+1] reloads so the next byte streams with no gap.
  - WRITE: after each 8th rising edge, mem[addr] <= rx byte and addr increments.
  - IGNORE: miso held 0 and mosi ignored until cs_rise.
  - Any state -> IDLE on cs_rise. done pulses for one clk and busy drops.
- Address wrap: addr increments modulo DEPTH, so DEPTH-1 wraps to 0.
- Partial bytes: a byte with fewer than 8 bits when cs rises is discarded. A partial WRITE byte is not stored.
- miso outside READ is driven 0, including during CMD/ADDR and while cs is high.
- Load port:
  - ld_we is honoured only while busy=0; it writes mem[ld_addr] <= ld_data in one cycle.
  - ld_we while busy=1 is dropped.
  - ld_we in the same clk as cs_fall is still accepted, because busy is not yet high.
- Reset mid-transaction: FSM returns to IDLE immediately and no memory write occurs. A new transaction requires a fresh cs_fall; cs already low at reset release is ignored until cs goes high and then low again.

Optional Feature:
- Macro SPI_RESP_STATS_EN.
- Defined: txn_count increments (wraps at 255) on each cs_rise that ends a READ or WRITE containing at least one complete data byte.
- Undefined: txn_count is tied to 0 and the counter logic is removed.

Decomposition:
- spi_resp_pkg holds:
  - CMD_READ = 8'h03 and CMD_WRITE = 8'h02
  - state enum state_t {IDLE, CMD, ADDR, READ, WRITE, IGNORE}
- Sub-module spi_edge_sync: parameterisable 2-flop synchroniser plus rise/fall pulse generator, instantiated for sclk and cs. mosi takes the synchroniser only.

Test Plan:
- Preload: load mem[0..3] = A5,3C,FF,01 via ld_we; then cs low, send 03,00, clock 32 bits -> miso returns A5 3C FF 01; done pulses once.
- Write then read back: send 02,05,77,88, cs high, then 03,05 -> reads 77 then 88.
- Address wrap (DEPTH=16): read starting at 0x0F for 2 bytes -> mem[15] then mem[0].
- Bad command: send opcode 0x9A then 16 bits -> miso stays 0, memory unchanged; a following valid read works.
- Abort: WRITE 02,02 then 5 data bits, cs high -> mem[2] unchanged, done pulses, FSM in IDLE.
- Load while busy, plus reset mid-read: ld_we during an active transaction -> mem unchanged. Assert rst during a READ byte -> miso=0 and busy=0; with SPI_RESP_STATS_EN defined, txn_count=0 after reset and 1 after one complete transaction.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared opcodes and FSM state encoding for the SPI memory responder.
package spi_resp_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser per bit followed by a registered-history edge detector.
// Flops reset to 0, so a line already low at reset release produces no fall pulse.
module spi_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave byte memory with parallel preload port and address auto-increment.
// Define SPI_RESP_STATS_EN to enable the completed-transaction counter on txn_count.
module spi_mem_responder
    import spi_resp_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        txn_count
);

    state_t state, state_nxt;

    logic [1:0] es_rise, es_fall;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic       mosi_meta, mosi_s;

    logic [2:0]             bit_cnt;
    logic [2:0]             tx_cnt;
    logic [6:0]             rx_sh;
    logic [7:0]             tx_sh;
    logic [7:0]             rx_byte;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      addr_inc;
    logic                   is_read;
    logic                   byte_done;
    logic [DEPTH-1:0][7:0]  mem;

    spi_edge_sync #(.WIDTH(2)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  ({cs, sclk}),
        .rise (es_rise),
        .fall (es_fall)
    );

    assign sclk_rise = es_rise[0];
    assign sclk_fall = es_fall[0];
    assign cs_rise   = es_rise[1];
    assign cs_fall   = es_fall[1];

    // mosi only needs the synchroniser; its delay matches the sclk path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
        end
    end

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign addr_inc  = addr + ADDR_W'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_nxt = CMD;
                CMD: if (byte_done)
                    state_nxt = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ADDR : IGNORE;
                ADDR: if (byte_done) state_nxt = is_read ? READ : WRITE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            tx_cnt  <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            addr    <= '0;
            is_read <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cs_rise) begin
                done    <= (state != IDLE);
                miso    <= 1'b0;
                bit_cnt <= '0;
                tx_cnt  <= '0;
            end else begin
                if (cs_fall) begin
                    bit_cnt <= '0;
                    tx_cnt  <= '0;
                    rx_sh   <= '0;
                end else if (sclk_rise && state != IDLE && state != IGNORE) begin
                    rx_sh   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                case (state)
                    CMD: if (byte_done) is_read <= (rx_byte == CMD_READ);
                    ADDR: if (byte_done) begin
                        addr   <= rx_byte[ADDR_W-1:0];
                        tx_sh  <= mem[rx_byte[ADDR_W-1:0]];
                        tx_cnt <= '0;
                    end
                    READ: if (sclk_fall) begin
                        miso   <= tx_sh[7];
                        tx_cnt <= tx_cnt + 3'd1;
                        // bit 0 just went out: fetch the next byte so streaming has no gap
                        if (tx_cnt == 3'd7) begin
                            addr  <= addr_inc;
                            tx_sh <= mem[addr_inc];
                        end else begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                    end
                    WRITE: if (byte_done) addr <= addr_inc;
                    default: ;
                endcase

                if (state != READ) miso <= 1'b0;
            end
        end
    end

    // Array is not reset; writes are blocked while rst is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == WRITE && byte_done && !cs_rise)
                mem[addr] <= rx_byte;
            else if (ld_we && state == IDLE)
                mem[ld_addr] <= ld_data;
        end
    end

`ifdef SPI_RESP_STATS_EN
    logic       data_seen;
    logic [7:0] txn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_seen <= 1'b0;
            txn_q     <= '0;
        end else if (cs_fall) begin
            data_seen <= 1'b0;
        end else if (cs_rise) begin
            if (data_seen && (state == READ || state == WRITE))
                txn_q <= txn_q + 8'd1;
            data_seen <= 1'b0;
        end else if (byte_done && (state == READ || state == WRITE)) begin
            data_seen <= 1'b1;
        end
    end

    assign txn_count = txn_q;
`else
    assign txn_count = 8'd0;
`endif

endmodule
